// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the EXE-stage iterative divider sequencer.
package div_seq_ctrl_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EXE <-> divider request/result bundle; EXE is the master, the sequencer the slave.
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_div;
    logic [WIDTH-1:0]       srca;
    logic [WIDTH-1:0]       srcb;
    logic                   ack;
    logic                   annul;
    logic [2*WIDTH-1:0]     result;
    logic                   ready;
    logic                   busy;

    modport master (
        output start, signed_div, srca, srcb, ack, annul,
        input  result, ready, busy
    );

    modport slave (
        input  start, signed_div, srca, srcb, ack, annul,
        output result, ready, busy
    );
endinterface

// File: rtl/div_seq_ctrl_step.sv
// One radix-2 restoring division step (combinational).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] d,
    input  logic             q_msb,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);
    logic [WIDTH:0] r_shift_s;
    logic [WIDTH:0] diff_s;

    // The shifted remainder keeps its carry bit so divisors above 2^(WIDTH-1) still compare correctly.
    always_comb begin
        r_shift_s = {r, q_msb};
        diff_s    = r_shift_s - {1'b0, d};
        q_bit     = ~diff_s[WIDTH];
        if (q_bit) begin
            r_next = diff_s[WIDTH-1:0];
        end else begin
            r_next = r_shift_s[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the shared restoring divider behind EXE DIV/DIVU.
// Optional DIV_ZERO_FAST_EN: divisor zero completes in one edge with the same result.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          resetn,
    div_seq_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_e        state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  rem_r, quo_r, div_r;
    logic              sign_q_r, sign_r_r;
    logic [2*WIDTH-1:0] result_r;
    logic              ready_r, busy_r;

    logic [WIDTH-1:0]  r_next_s;
    logic              q_bit_s;
    logic              last_s, fast_hit_s, sa_s, sb_s;
    logic [WIDTH-1:0]  abs_a_s, abs_b_s, q_final_s, quot_fix_s, rem_fix_s;
    logic [WIDTH-1:0]  fast_quot_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (rem_r),
        .d      (div_r),
        .q_msb  (quo_r[WIDTH-1]),
        .r_next (r_next_s),
        .q_bit  (q_bit_s)
    );

    // Operand magnitudes, sign fix-up of the final step and the zero-divisor shortcut.
    always_comb begin
        sa_s        = bus.signed_div & bus.srca[WIDTH-1];
        sb_s        = bus.signed_div & bus.srcb[WIDTH-1];
        abs_a_s     = sa_s ? ({WIDTH{1'b0}} - bus.srca) : bus.srca;
        abs_b_s     = sb_s ? ({WIDTH{1'b0}} - bus.srcb) : bus.srcb;
        last_s      = (cnt_r == CNT_W'(WIDTH - 1));
        q_final_s   = {quo_r[WIDTH-2:0], q_bit_s};
        quot_fix_s  = sign_q_r ? ({WIDTH{1'b0}} - q_final_s) : q_final_s;
        rem_fix_s   = sign_r_r ? ({WIDTH{1'b0}} - r_next_s) : r_next_s;
        // Negated all-ones is 1, matching what the slow path yields for a negative dividend.
        fast_quot_s = sa_s ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
`ifdef DIV_ZERO_FAST_EN
        fast_hit_s  = (bus.srcb == {WIDTH{1'b0}});
`else
        fast_hit_s  = 1'b0;
`endif
    end

    // Next-state logic; annul overrides ack and start.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (bus.annul) begin
                    state_next_s = DIV_IDLE;
                end else if (bus.start) begin
                    state_next_s = fast_hit_s ? DIV_DONE : DIV_BUSY;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (bus.annul) begin
                    state_next_s = DIV_IDLE;
                end else if (last_s) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_BUSY;
                end
            end
            DIV_DONE: begin
                if (bus.annul || bus.ack) begin
                    state_next_s = DIV_IDLE;
                end else begin
                    state_next_s = DIV_DONE;
                end
            end
            default: state_next_s = DIV_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= DIV_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == DIV_DONE);
            busy_r  <= (state_next_s == DIV_BUSY);
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            div_r    <= {WIDTH{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (bus.start && !bus.annul) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        rem_r    <= {WIDTH{1'b0}};
                        quo_r    <= abs_a_s;
                        div_r    <= abs_b_s;
                        sign_q_r <= sa_s ^ sb_s;
                        sign_r_r <= sa_s;
                        if (fast_hit_s) begin
                            result_r <= {bus.srca, fast_quot_s};
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!bus.annul) begin
                        rem_r <= r_next_s;
                        quo_r <= q_final_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (last_s) begin
                            result_r <= {rem_fix_s, quot_fix_s};
                        end
                    end
                end
                DIV_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.ready  = ready_r;
    assign bus.busy   = busy_r;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed, table-driven bench for div_seq_ctrl plus hand-written corner sequences.
module tb_div_seq_ctrl;
    logic clk;
    logic resetn;
    int   total;
    int   bad;

    div_seq_ctrl_if #(.WIDTH(32)) bus ();

    div_seq_ctrl #(.WIDTH(32)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for ready, report edges to ready and busy cycles seen.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cnt);
        bus.start = 1'b1; bus.signed_div = sgn; bus.srca = a; bus.srcb = b;
        tick();
        bus.start = 1'b0;
        edges = 1;
        busy_cnt = 0;
        while (!bus.ready && edges < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    initial begin
        int edges;
        int busy_cnt;
        logic [63:0] held;
        total = 0;
        bad   = 0;
        vecs[0] = '{"divu_100_7",     1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
        vecs[1] = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD}};
        vecs[2] = '{"div_7_m2",       1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD}};
        vecs[3] = '{"div_min_m1",     1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000}};
        vecs[4] = '{"divu_5_0",       1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFFFFFF}};
        vecs[5] = '{"div_m7_0",       1'b1, 32'hFFFFFFF9,   32'd0,          {32'hFFFFFFF9,   32'd1}};
        vecs[6] = '{"divu_big_div",   1'b0, 32'hFFFFFFFF,   32'h80000001,   {32'h7FFFFFFE,   32'd1}};
        vecs[7] = '{"div_m100_m7",    1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE,   32'd14}};

        resetn = 1'b0;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.srca = 32'd0; bus.srcb = 32'd0;
        bus.ack = 1'b0; bus.annul = 1'b0;
        tick(); tick();
        check("reset_result", bus.result, 64'd0);
        check("reset_ready", {63'd0, bus.ready}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, edges, busy_cnt);
            check({vecs[i].name, "_result"}, bus.result, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 64'(edges), 64'(exp_lat(vecs[i].b)));
            check({vecs[i].name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat(vecs[i].b) - 1));
            do_ack();
            check({vecs[i].name, "_ready_after_ack"}, {63'd0, bus.ready}, 64'd0);
        end

        // annul at BUSY cycle 10; previous result (div_m100_m7) must remain
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.srca = 32'd100; bus.srcb = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        check("annul_busy", {63'd0, bus.busy}, 64'd0);
        check("annul_ready", {63'd0, bus.ready}, 64'd0);
        check("annul_result_kept", bus.result, {32'hFFFFFFFE, 32'd14});
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, edges, busy_cnt);
        check("after_annul_result", bus.result, {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("after_annul_latency", 64'(edges), 64'd33);

        // DONE hold with ack low and a stray start
        held = bus.result;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.signed_div = 1'b0; bus.srca = 32'd9; bus.srcb = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            check("hold_result", bus.result, held);
            check("hold_ready", {63'd0, bus.ready}, 64'd1);
            check("hold_busy", {63'd0, bus.busy}, 64'd0);
        end
        bus.start = 1'b0;
        do_ack();
        check("ack_ready", {63'd0, bus.ready}, 64'd0);
        check("ack_busy", {63'd0, bus.busy}, 64'd0);
        check("ack_result_kept", bus.result, held);

        // simultaneous start+annul in IDLE stays IDLE
        bus.start = 1'b1; bus.annul = 1'b1; bus.srca = 32'd100; bus.srcb = 32'd7;
        tick();
        bus.start = 1'b0; bus.annul = 1'b0;
        check("start_annul_busy", {63'd0, bus.busy}, 64'd0);
        tick();
        check("start_annul_busy2", {63'd0, bus.busy}, 64'd0);
        check("start_annul_ready", {63'd0, bus.ready}, 64'd0);

        // reset mid-BUSY
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.srca = 32'd100; bus.srcb = 32'd7;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
        resetn = 1'b0;
        tick();
        check("midreset_result", bus.result, 64'd0);
        check("midreset_busy", {63'd0, bus.busy}, 64'd0);
        check("midreset_ready", {63'd0, bus.ready}, 64'd0);
        resetn = 1'b1;
        tick();
        run_op(1'b0, 32'd100, 32'd7, edges, busy_cnt);
        check("post_reset_result", bus.result, {32'd2, 32'd14});
        do_ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
